// File: rtl/decoder_scan_seq_pkg.sv
// Shared definitions for the decoder scan sequencer: state encoding and step sizing.
package decoder_scan_seq_pkg;
    localparam int STEP_W    = 3;
    localparam int NUM_STEPS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    typedef logic [STEP_W-1:0]    step_t;
    typedef logic [NUM_STEPS-1:0] mask_t;
endpackage

// File: rtl/decoder_scan_seq_if.sv
// Control and decoder-drive bundle between the sequencer and whoever commands it.
interface decoder_scan_seq_if;
    import decoder_scan_seq_pkg::*;

    logic  start;
    logic  continuous;
    logic  stop;
    mask_t step_mask;
    logic  G_L1;
    logic  G_L2;
    logic  A1;
    logic  B1;
    logic  A2;
    logic  B2;
    step_t step;
    logic  busy;
    logic  sweep_done;

    modport master (
        output start, continuous, stop, step_mask,
        input  G_L1, G_L2, A1, B1, A2, B2, step, busy, sweep_done
    );

    modport slave (
        input  start, continuous, stop, step_mask,
        output G_L1, G_L2, A1, B1, A2, B2, step, busy, sweep_done
    );
endinterface

// File: rtl/decoder_scan_seq_next_step_find.sv
// Combinational step selector: next enabled step above the current one, and the lowest enabled step.
module decoder_scan_seq_next_step_find
    import decoder_scan_seq_pkg::*;
(
    input  mask_t mask_i,
    input  step_t step_i,
    output step_t next_o,
    output logic  found_o,
    output step_t lowest_o
);

    // Descending scan: the last hit wins, giving the lowest qualifying index.
    always_comb begin
        next_o   = '0;
        found_o  = 1'b0;
        lowest_o = '0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                lowest_o = step_t'(i);
                if (i > int'(step_i)) begin
                    next_o  = step_t'(i);
                    found_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decoder_scan_seq.sv
// Sweep sequencer for a dual 2-to-4 decoder: blank/dwell per step, skip mask, stop, continuous wrap.
module decoder_scan_seq
    import decoder_scan_seq_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int BLANK = 2,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    decoder_scan_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);

    state_e           state_q, state_d;
    step_t            step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             g1_q, g1_d;
    logic             g2_q, g2_d;
    logic [1:0]       addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    step_t next_step;
    logic  next_found;
    step_t lowest_step;

    decoder_scan_seq_next_step_find u_find (
        .mask_i   (bus.step_mask),
        .step_i   (step_q),
        .next_o   (next_step),
        .found_o  (next_found),
        .lowest_o (lowest_step)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (bus.start && (bus.step_mask != '0)) begin
                    state_d = ST_BLANK;
                    step_d  = lowest_step;
                    cnt_d   = BLANK_LD;
                end
            end
            ST_BLANK: begin
                if (bus.stop) stop_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = DWELL_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (bus.stop) stop_d = 1'b1;
                end else if (stop_q || bus.stop) begin
                    // A stop still reports completion when the halted step was the last one.
                    state_d = ST_IDLE;
                    stop_d  = 1'b0;
                    done_d  = !next_found;
                end else if (next_found) begin
                    state_d = ST_BLANK;
                    step_d  = next_step;
                    cnt_d   = BLANK_LD;
                end else begin
                    done_d = 1'b1;
                    if (bus.continuous && (bus.step_mask != '0)) begin
                        state_d = ST_BLANK;
                        step_d  = lowest_step;
                        cnt_d   = BLANK_LD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                stop_d  = 1'b0;
            end
        endcase

        // Outputs are derived from the next state so they register in step with it.
        g1_d   = !((state_d == ST_ACTIVE) && !step_d[2]);
        g2_d   = !((state_d == ST_ACTIVE) &&  step_d[2]);
        addr_d = step_d[1:0];
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            g1_q    <= 1'b1;
            g2_q    <= 1'b1;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.G_L1       = g1_q;
    assign bus.G_L2       = g2_q;
    assign bus.A1         = addr_q[0];
    assign bus.B1         = addr_q[1];
    assign bus.A2         = addr_q[0];
    assign bus.B2         = addr_q[1];
    assign bus.step       = step_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = done_q;

endmodule
